// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Sequencer that feeds a combinational ALU from a 4x8 register file.
//            Define ALU_BYPASS_EN to skip the READ state (2-cycle throughput).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
   parameter int W    = 8,
   parameter int NREG = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   in_op,
   input  logic [1:0]   in_ra,
   input  logic [1:0]   in_rb,
   input  logic [1:0]   in_rd,
   input  logic         in_wb,
   input  logic         ld_en,
   input  logic [1:0]   ld_addr,
   input  logic [W-1:0] ld_data,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [3:0]   alu_op,
   input  logic [W-1:0] alu_c,
   input  logic [W-1:0] alu_flags,
   output logic [W-1:0] result,
   output logic [W-1:0] flags,
   output logic         done,
   input  logic [1:0]   dbg_addr,
   output logic [W-1:0] dbg_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2
   } state_t;

   state_t         state_q, state_d;
`ifndef ALU_BYPASS_EN
   logic [3:0]     op_q, op_d;
   logic [1:0]     ra_q, ra_d;
   logic [1:0]     rb_q, rb_d;
`endif
   logic [1:0]     rd_q, rd_d;
   logic           wb_q, wb_d;
   logic [W-1:0]   rf_q [NREG];
   logic [W-1:0]   rf_d [NREG];
   logic [W-1:0]   alu_a_q, alu_a_d;
   logic [W-1:0]   alu_b_q, alu_b_d;
   logic [3:0]     alu_op_q, alu_op_d;
   logic [W-1:0]   result_q, result_d;
   logic [W-1:0]   flags_q, flags_d;
   logic           done_q, done_d;

   always_comb begin
      state_d  = state_q;
`ifndef ALU_BYPASS_EN
      op_d     = op_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
`endif
      rd_d     = rd_q;
      wb_d     = wb_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      result_d = result_q;
      flags_d  = flags_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               rd_d = in_rd;
               wb_d = in_wb;
`ifdef ALU_BYPASS_EN
               alu_a_d  = rf_q[in_ra];
               alu_b_d  = rf_q[in_rb];
               alu_op_d = in_op;
               state_d  = EXEC;
`else
               op_d    = in_op;
               ra_d    = in_ra;
               rb_d    = in_rb;
               state_d = READ;
`endif
            end
         end
`ifndef ALU_BYPASS_EN
         READ: begin
            alu_a_d  = rf_q[ra_q];
            alu_b_d  = rf_q[rb_q];
            alu_op_d = op_q;
            state_d  = EXEC;
         end
`endif
         EXEC: begin
            result_d = alu_c;
            flags_d  = alu_flags;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Write-back is applied after the load port so it wins on an address clash.
      for (int i = 0; i < NREG; i++) begin
         rf_d[i] = rf_q[i];
         if (ld_en && (ld_addr == 2'(i)))
            rf_d[i] = ld_data;
         if ((state_q == EXEC) && wb_q && (rd_q == 2'(i)))
            rf_d[i] = alu_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
`ifndef ALU_BYPASS_EN
         op_q     <= '0;
         ra_q     <= '0;
         rb_q     <= '0;
`endif
         rd_q     <= '0;
         wb_q     <= 1'b0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         result_q <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
         for (int i = 0; i < NREG; i++)
            rf_q[i] <= '0;
      end else begin
         state_q  <= state_d;
`ifndef ALU_BYPASS_EN
         op_q     <= op_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
`endif
         rd_q     <= rd_d;
         wb_q     <= wb_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         done_q   <= done_d;
         for (int i = 0; i < NREG; i++)
            rf_q[i] <= rf_d[i];
      end
   end

   assign in_ready = (state_q == IDLE);
   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_op   = alu_op_q;
   assign result   = result_q;
   assign flags    = flags_q;
   assign done     = done_q;
   assign dbg_data = rf_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Bench for alu_seq with a behavioural ALU and register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

`ifdef ALU_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_AND    = 4'd2;
   localparam logic [3:0] OP_OR     = 4'd3;
   localparam logic [3:0] OP_XOR    = 4'd4;
   localparam logic [3:0] OP_MIRROR = 4'd5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_op = '0;
   logic [1:0] in_ra = '0, in_rb = '0, in_rd = '0;
   logic       in_wb = 1'b0;
   logic       ld_en = 1'b0;
   logic [1:0] ld_addr = '0;
   logic [7:0] ld_data = '0;
   logic [7:0] alu_a, alu_b, alu_c, alu_flags, result, flags, dbg_data;
   logic [3:0] alu_op;
   logic       done;
   logic [1:0] dbg_addr = '0;

   int checks = 0;
   int errors = 0;
   logic [7:0] m [4];

   always #5 clk = ~clk;

   alu_seq #(.W(8), .NREG(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_wb(in_wb),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_c(alu_c), .alu_flags(alu_flags),
      .result(result), .flags(flags), .done(done),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Returns {flags, c}; flags = {6'b0, zero, carry/borrow}.
   function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int         s;
      logic [7:0] c;
      logic       cy;
      cy = 1'b0;
      case (op)
         OP_ADD: begin s = int'(a) + int'(b); c = s[7:0]; cy = (s > 255); end
         OP_SUB: begin s = int'(a) - int'(b); c = s[7:0]; cy = (s < 0); end
         OP_AND: c = a & b;
         OP_OR:  c = a | b;
         OP_XOR: c = a ^ b;
         OP_MIRROR: for (int i = 0; i < 8; i++) c[i] = a[7-i];
         default: c = a;
      endcase
      return {6'b0, (c == 8'h00), cy, c};
   endfunction

   always_comb {alu_flags, alu_c} = alu_fn(alu_op, alu_a, alu_b);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1 ld_en = 1'b0;
      m[a] = d;
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      chk("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   // Issues one instruction starting at the current negedge and returns at the done negedge.
   task automatic run(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                      input logic [1:0] rd, input logic wb, input logic hold,
                      input logic do_ld, input logic [1:0] la, input logic [7:0] ld_d);
      logic [15:0] exp;
      logic [7:0]  ea, eb;
      int n;
      if (!in_ready) wait_ready();
      ea = m[ra]; eb = m[rb];
      exp = alu_fn(op, ea, eb);
      in_op = op; in_ra = ra; in_rb = rb; in_rd = rd; in_wb = wb;
      in_valid = 1'b1; dbg_addr = rd;
      @(posedge clk);
      @(negedge clk);
      in_valid = hold;
      n = 0;
      while (!done && n < 8) begin
         chk("busy_ready", 32'(in_ready), 32'd0);
         chk("rd_before_exec", 32'(dbg_data), 32'(m[rd]));
         if (hold) begin
            in_op = 4'($urandom_range(0, 15)); in_ra = 2'($urandom); in_rb = 2'($urandom);
            in_rd = 2'($urandom); in_wb = 1'($urandom);
         end
         if (do_ld && n == LAT - 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ld_d; end
         @(posedge clk); #1 ld_en = 1'b0;
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      chk("latency", 32'(n), 32'(LAT));
      chk("done_ready", 32'(in_ready), 32'd1);
      chk("alu_a", 32'(alu_a), 32'(ea));
      chk("alu_b", 32'(alu_b), 32'(eb));
      chk("alu_op", 32'(alu_op), 32'(op));
      chk("result", 32'(result), 32'(exp[7:0]));
      chk("flags", 32'(flags), 32'(exp[15:8]));
      if (do_ld) m[la] = ld_d;
      if (wb) m[rd] = exp[7:0];
      chk("rd_after", 32'(dbg_data), 32'(m[rd]));
      if (do_ld) begin
         dbg_addr = la; #1;
         chk("ld_after", 32'(dbg_data), 32'(m[la]));
         dbg_addr = rd;
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m[i] = 8'h00;

      // Reset state
      #12;
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // AND: CA & AA = 8A into r2
      load(2'd0, 8'hCA);
      load(2'd1, 8'hAA);
      @(negedge clk);
      run(OP_AND, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
      chk("and_result", 32'(result), 32'h8A);
      chk("and_r2", 32'(dbg_data), 32'h8A);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);

      // ADD then SUB issued in the done cycle
      run(OP_ADD, 2'd0, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
      chk("add_r3", 32'(dbg_data), 32'h74);
      run(OP_SUB, 2'd0, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      chk("sub_result", 32'(result), 32'h20);
      chk("sub_r3_kept", 32'(dbg_data), 32'h74);

      // Mirror with all three addresses equal
      load(2'd0, 8'h2F);
      @(negedge clk);
      run(OP_MIRROR, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
      chk("mirror_a", 32'(alu_a), 32'h2F);
      chk("mirror_r0", 32'(dbg_data), 32'hF4);

      // Load colliding with write-back, then load to a different register
      run(OP_OR, 2'd1, 2'd3, 2'd2, 1'b1, 1'b0, 1'b1, 2'd2, 8'h55);
      chk("wb_wins", 32'(dbg_data), 32'(8'hAA | 8'h74));
      run(OP_XOR, 2'd1, 2'd3, 2'd2, 1'b1, 1'b0, 1'b1, 2'd1, 8'h3C);
      chk("xor_r2", 32'(dbg_data), 32'(8'hAA ^ 8'h74));
      dbg_addr = 2'd1; #1;
      chk("ld_r1", 32'(dbg_data), 32'h3C);

      // in_valid held high with changing fields while busy
      run(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);

      // Randomized traffic
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 3) == 0) load(2'($urandom), 8'($urandom));
         run(4'($urandom_range(0, 6)), 2'($urandom), 2'($urandom), 2'($urandom),
             1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
             2'($urandom), 8'($urandom));
      end

      // Reset while in EXEC
      load(2'd0, 8'h81);
      load(2'd1, 8'h7E);
      @(negedge clk);
      in_op = OP_OR; in_ra = 2'd0; in_rb = 2'd1; in_rd = 2'd2; in_wb = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < LAT - 1; i++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_result", 32'(result), 32'd0);
      chk("mid_rst_flags", 32'(flags), 32'd0);
      chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
      chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
      chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_rst_no_done", 32'(done), 32'd0);
      end
      for (int a = 0; a < 4; a++) begin
         dbg_addr = 2'(a); #1;
         chk("mid_rst_reg", 32'(dbg_data), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_no_done", 32'(done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
